// File: rtl/noise_pulse_conditioner.sv
`timescale 1ns/100ps
// noise_pulse_conditioner
// Front end for the photodiode comparator. It synchronises the raw comparator
// output, rejects glitches and re-triggers, and emits one single-cycle
// noise_valid strobe per qualified pulse. It also reports how many strobes
// fell into each fixed-length window, for telemetry.
module noise_pulse_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_WIDTH     = 2,
  parameter int HOLDOFF       = 2,
  parameter int WINDOW_CYCLES = 10000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             noise_in,
  output logic             noise_valid,
  output logic [CNT_W-1:0] window_count,
  output logic             count_valid,
  output logic             window_sat,
  output logic [1:0]       debug_state
);

  localparam int WCNT_W = $clog2(MIN_WIDTH + 1);
  localparam int HCNT_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam int TMR_W  = $clog2(WINDOW_CYCLES);

  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] MIN_W_C   = WCNT_W'(MIN_WIDTH);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HOLD_C    = HCNT_W'(HOLDOFF);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam bit                EMIT_NOW  = (MIN_WIDTH == 1);
  localparam bit                NO_HOLD   = (HOLDOFF == 0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUAL     = 2'd1,
    ST_WAIT_LOW = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  // Synchroniser
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   noise_sync;

  // Pulse qualifier
  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                noise_valid_q, noise_valid_d;

  // Window statistics
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    acc_q, acc_d, acc_next;
  logic                sat_q, sat_d, sat_next;
  logic [CNT_W-1:0]    window_count_q, window_count_d;
  logic                window_sat_q, window_sat_d;
  logic                count_valid_q, count_valid_d;

  // Shift the raw comparator level into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], noise_in};
  end

  assign noise_sync = sync_q[SYNC_STAGES-1];

  // Synchroniser flops; they keep running even while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Qualifier next state: width check, one strobe per pulse, then hold-off.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    hcnt_d        = hcnt_q;
    noise_valid_d = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (noise_sync) begin
            if (EMIT_NOW) begin
              noise_valid_d = 1'b1;
              state_d       = ST_WAIT_LOW;
              wcnt_d        = '0;
            end else begin
              state_d = ST_QUAL;
              wcnt_d  = WCNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_QUAL: begin
          if (!noise_sync) begin
            // Too short: a glitch, drop it silently.
            state_d = ST_IDLE;
            wcnt_d  = '0;
          end else if ((wcnt_q + WCNT_ONE) == MIN_W_C) begin
            noise_valid_d = 1'b1;
            state_d       = ST_WAIT_LOW;
            wcnt_d        = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_ONE;
          end
        end
        ST_WAIT_LOW: begin
          if (noise_sync) begin
            state_d = ST_WAIT_LOW;
          end else if (NO_HOLD) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            hcnt_d  = HOLD_C;
          end
        end
        ST_HOLD: begin
          // Input is ignored here so ringing after the fall cannot re-trigger.
          if (hcnt_q <= HCNT_ONE) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q - HCNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Qualifier state and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wcnt_q        <= '0;
      hcnt_q        <= '0;
      noise_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      hcnt_q        <= hcnt_d;
      noise_valid_q <= noise_valid_d;
    end
  end

  // Saturating accumulate of the current strobe; sat flags a counter at ceiling.
  always_comb begin
    if (noise_valid_q && (acc_q != CNT_MAX)) begin
      acc_next = acc_q + CNT_ONE;
    end else begin
      acc_next = acc_q;
    end
    sat_next = sat_q | (acc_next == CNT_MAX);
  end

  // Window timer: on the last cycle publish the total (including a coincident strobe) and restart.
  always_comb begin
    timer_d        = timer_q;
    acc_d          = acc_q;
    sat_d          = sat_q;
    window_count_d = window_count_q;
    window_sat_d   = window_sat_q;
    count_valid_d  = 1'b0;
    if (!enable) begin
      timer_d = '0;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else if (timer_q == TMR_LAST) begin
      window_count_d = acc_next;
      window_sat_d   = sat_next;
      count_valid_d  = 1'b1;
      timer_d        = '0;
      acc_d          = '0;
      sat_d          = 1'b0;
    end else begin
      timer_d = timer_q + TMR_ONE;
      acc_d   = acc_next;
      sat_d   = sat_next;
    end
  end

  // Window statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q        <= '0;
      acc_q          <= '0;
      sat_q          <= 1'b0;
      window_count_q <= '0;
      window_sat_q   <= 1'b0;
      count_valid_q  <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      acc_q          <= acc_d;
      sat_q          <= sat_d;
      window_count_q <= window_count_d;
      window_sat_q   <= window_sat_d;
      count_valid_q  <= count_valid_d;
    end
  end

  assign noise_valid  = noise_valid_q;
  assign window_count = window_count_q;
  assign count_valid  = count_valid_q;
  assign window_sat   = window_sat_q;
  assign debug_state  = state_q;

endmodule
